defuzz_centroid: RTL and testbench
==================================

# defuzz_centroid

Parametrised, sequential centroid defuzzifier: accepts N_SETS membership degrees with a programmable singleton centre per set and produces crisp = Σ(mu_i·c_i) / Σ(mu_i). It sits at the output of the fuzzy inference stage in the FLC datapath. It replaces the combinational fixed-five-set defuzzifier with valid/ready handshakes, runtime centres, a multi-cycle restoring divider and explicit zero-weight handling.

## Interface
Parameters:
- N_SETS, 5, number of output fuzzy sets (≥2); index 0 = most negative set.
- MU_W, 8, membership degree width (unsigned).
- C_W, 8, centre and crisp output width (unsigned).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  mu/centre vector valid.
- in_ready  out  1  block can accept (IDLE only).
- mu  in  N_SETS*MU_W  degrees, set i at [i*MU_W +: MU_W].
- centre  in  N_SETS*C_W  singleton centres, set i at [i*C_W +: C_W].
- out_valid  out  1  crisp result valid.
- out_ready  in  1  consumer accepts result.
- crisp  out  C_W  defuzzified value.
- div_zero  out  1  Σmu was zero for this result.

## Operation
- Derived widths: SUM_W = MU_W + clog2(N_SETS); NUM_W = MU_W + C_W + clog2(N_SETS). All arithmetic unsigned, no overflow possible at these widths.
- FSM: IDLE → ACCUM → DIVIDE → DONE → IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, register mu and centre vectors; clear num/den; go ACCUM.
- ACCUM: one set per cycle, index 0..N_SETS-1: num += mu_i·c_i, den += mu_i. After last index: den==0 → DONE with crisp=0, div_zero=1; else → DIVIDE.
- DIVIDE: restoring division, one quotient bit per cycle, NUM_W cycles, MSB first. Quotient always ≤ max centre, so the low C_W bits are the result; upper bits are zero by construction.
- DONE: out_valid=1; crisp and div_zero stable until out_valid&&out_ready, then IDLE.
- Inputs are ignored outside IDLE; the captured copy is used, so mu/centre may change after the handshake.

## Timing
- Reset (rst high at a clock edge): state IDLE, out_valid=0, crisp=0, div_zero=0, accumulators 0. in_ready=0 while rst is high, 1 in the first cycle after release.
- Input handshake at edge T: ACCUM for edges T+1..T+N_SETS; DIVIDE for edges T+N_SETS+1..T+N_SETS+NUM_W; out_valid high from cycle after edge T+N_SETS+NUM_W. Defaults: 25 cycles from accept to out_valid.
- Zero-weight path: out_valid high after edge T+N_SETS (6 cycles at defaults).
- Output handshake at edge U: out_valid low and in_ready high from the cycle after U. No accept in the same cycle as an output handshake; minimum throughput one result per N_SETS+NUM_W+2 cycles.
- out_ready is ignored while out_valid=0. Backpressure holds DONE indefinitely.
- rst mid-ACCUM/DIVIDE/DONE: transaction discarded, no out_valid pulse, reset values as above.

## Configuration
- DEFUZZ_ROUND_EN defined: numerator preloaded with num + (den>>1) before DIVIDE, so crisp is rounded to nearest (half-up). The result still fits C_W.
- Not defined: crisp = floor(num/den), truncating. Latency is identical either way. Zero-weight path is unaffected.

## Structure
- Package defuzz_pkg: FSM state enum, clog2-based width functions (SUM_W, NUM_W), and default centre constants for five-set use (NL=0, NS=64, Z=128, PS=192, PL=255).
- Sub-module seq_divider: parametrised restoring divider with start, dividend, divisor, busy, done and quotient ports, NUM_W cycles per divide. It is instantiated once. The FSM, accumulators and handshakes remain in defuzz_centroid.

## Test plan
Default parameters, default centres unless stated.
- Only Z set: mu Z=200, others 0 → crisp=128, div_zero=0, out_valid 25 cycles after accept.
- Rounding: mu PS=100, PL=100 → num=44700, den=200. Without DEFUZZ_ROUND_EN crisp=223; with it crisp=224.
- Zero weight: all mu=0 → crisp=0, div_zero=1, out_valid 6 cycles after accept.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → crisp, div_zero and out_valid stable, in_ready=0, in_valid pulses ignored. Release → in_ready=1 next cycle.
- Runtime centres: centres all 50, mu arbitrary nonzero → crisp=50. Change mu/centre during ACCUM → result unchanged.
- Reset mid-DIVIDE: assert rst 10 cycles after accept → no out_valid. After release in_ready=1, and a new transaction with mu NL=255 yields crisp=0, div_zero=0.

Source files
------------

// File: rtl/defuzz_pkg.sv
// Shared types, width helpers and default five-set centres for the centroid defuzzifier.
package defuzz_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DIVIDE = 2'd2,
    DONE   = 2'd3
  } defuzzState_t;

  // Index width for walking the sets (nSets is at least 2).
  function automatic int unsigned idxWidth(input int unsigned nSets);
    return $clog2(nSets);
  endfunction

  // Width of the membership-degree sum.
  function automatic int unsigned sumWidth(input int unsigned muW, input int unsigned nSets);
    return muW + $clog2(nSets);
  endfunction

  // Width of the weighted-centre sum.
  function automatic int unsigned numWidth(input int unsigned muW, input int unsigned cW,
                                           input int unsigned nSets);
    return muW + cW + $clog2(nSets);
  endfunction

  localparam logic [7:0] CENTRE_NL = 8'd0;
  localparam logic [7:0] CENTRE_NS = 8'd64;
  localparam logic [7:0] CENTRE_Z  = 8'd128;
  localparam logic [7:0] CENTRE_PS = 8'd192;
  localparam logic [7:0] CENTRE_PL = 8'd255;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle, MSB first. The first bit is resolved on the
// start edge itself, so a divide takes exactly W edges and done pulses in the following cycle.
module seq_divider #(
  parameter int unsigned W  = 19,
  parameter int unsigned DW = 11,
  parameter int unsigned QW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  dividend,
  input  logic [DW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] quotient
);

  localparam int unsigned CNT_W = $clog2(W + 1);

  logic [DW-1:0]    rem;
  logic [DW-1:0]    divisorQ;
  logic [W-1:0]     quo;
  logic [CNT_W-1:0] cnt;

  logic [DW-1:0] remSel;
  logic [DW-1:0] divSel;
  logic [W-1:0]  quoSel;
  logic [DW:0]   shifted;
  logic          fits;
  logic [DW-1:0] remNext;
  logic [W-1:0]  quoNext;

  // One restoring step; on start the operands come straight from the ports.
  always_comb begin
    remSel  = start ? '0 : rem;
    divSel  = start ? divisor : divisorQ;
    quoSel  = start ? dividend : quo;
    shifted = {remSel, quoSel[W-1]};
    fits    = (shifted >= {1'b0, divSel});
    remNext = fits ? DW'(shifted - {1'b0, divSel}) : DW'(shifted);
    quoNext = {quoSel[W-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem      <= '0;
      divisorQ <= '0;
      quo      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem      <= remNext;
        quo      <= quoNext;
        divisorQ <= divisor;
        cnt      <= CNT_W'(1);
        busy     <= 1'b1;
      end else if (busy) begin
        rem <= remNext;
        quo <= quoNext;
        cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  // Quotient never exceeds the largest centre, so only the low bits are exported.
  assign quotient = quo[QW-1:0];

endmodule

// File: rtl/defuzz_centroid.sv
// Sequential centroid defuzzifier: crisp = sum(mu_i*c_i) / sum(mu_i) with valid/ready handshakes.
// Optional build macro DEFUZZ_ROUND_EN selects round-half-up instead of truncation.
module defuzz_centroid
  import defuzz_pkg::*;
#(
  parameter int unsigned N_SETS = 5,
  parameter int unsigned MU_W   = 8,
  parameter int unsigned C_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_SETS*MU_W-1:0] mu,
  input  logic [N_SETS*C_W-1:0]  centre,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [C_W-1:0]         crisp,
  output logic                   div_zero
);

  localparam int unsigned SUM_W  = sumWidth(MU_W, N_SETS);
  localparam int unsigned NUM_W  = numWidth(MU_W, C_W, N_SETS);
  localparam int unsigned IDX_W  = idxWidth(N_SETS);
  localparam int unsigned PROD_W = MU_W + C_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SETS - 1);

  defuzzState_t state;
  defuzzState_t stateNext;

  logic [N_SETS*MU_W-1:0] muQ;
  logic [N_SETS*C_W-1:0]  centreQ;
  logic [NUM_W-1:0]       num;
  logic [SUM_W-1:0]       den;
  logic [IDX_W-1:0]       idx;

  logic [MU_W-1:0]   muSel;
  logic [C_W-1:0]    cSel;
  logic [PROD_W-1:0] prod;
  logic [NUM_W-1:0]  numAcc;
  logic [SUM_W-1:0]  denAcc;
  logic [NUM_W-1:0]  dividend;

  logic load;
  logic accumEn;
  logic divStart;
  logic finishZero;
  logic finishDiv;
  logic releaseOut;

  logic           divBusy;
  logic           divDone;
  logic [C_W-1:0] quotient;

  // Current set's contribution to the running sums.
  always_comb begin
    muSel  = muQ[idx*MU_W +: MU_W];
    cSel   = centreQ[idx*C_W +: C_W];
    prod   = PROD_W'(muSel) * PROD_W'(cSel);
    numAcc = num + NUM_W'(prod);
    denAcc = den + SUM_W'(muSel);
  end

  // The divider is loaded from the final sums on the last accumulate cycle.
`ifdef DEFUZZ_ROUND_EN
  assign dividend = numAcc + NUM_W'(denAcc >> 1);
`else
  assign dividend = numAcc;
`endif

  // Next-state and control strobes.
  always_comb begin
    stateNext  = state;
    load       = 1'b0;
    accumEn    = 1'b0;
    divStart   = 1'b0;
    finishZero = 1'b0;
    finishDiv  = 1'b0;
    releaseOut = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load      = 1'b1;
          stateNext = ACCUM;
        end
      end
      ACCUM: begin
        accumEn = 1'b1;
        if (idx == LAST_IDX) begin
          if (denAcc == '0) begin
            finishZero = 1'b1;
            stateNext  = DONE;
          end else begin
            divStart  = !divBusy;
            stateNext = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        if (divDone) begin
          finishDiv = 1'b1;
          stateNext = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          releaseOut = 1'b1;
          stateNext  = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      muQ       <= '0;
      centreQ   <= '0;
      num       <= '0;
      den       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      crisp     <= '0;
      div_zero  <= 1'b0;
    end else begin
      state <= stateNext;
      if (load) begin
        muQ     <= mu;
        centreQ <= centre;
        num     <= '0;
        den     <= '0;
        idx     <= '0;
      end
      if (accumEn) begin
        num <= numAcc;
        den <= denAcc;
        idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      end
      if (finishZero) begin
        out_valid <= 1'b1;
        crisp     <= '0;
        div_zero  <= 1'b1;
      end
      if (finishDiv) begin
        out_valid <= 1'b1;
        crisp     <= quotient;
        div_zero  <= 1'b0;
      end
      if (releaseOut) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Ready drops immediately while reset is held so nothing is accepted during reset.
  assign in_ready = (state == IDLE) && !rst;

  seq_divider #(
    .W (NUM_W),
    .DW(SUM_W),
    .QW(C_W)
  ) uDivider (
    .clk     (clk),
    .rst     (rst),
    .start   (divStart),
    .dividend(dividend),
    .divisor (denAcc),
    .busy    (divBusy),
    .done    (divDone),
    .quotient(quotient)
  );

endmodule

// File: tb/tb_defuzz_centroid.sv
// Randomized self-checking bench for defuzz_centroid against a plain-arithmetic centroid model.
module tb_defuzz_centroid;
  import defuzz_pkg::*;

  localparam int unsigned N     = 5;
  localparam int unsigned MU_W  = 8;
  localparam int unsigned C_W   = 8;
  localparam int unsigned NUM_W = MU_W + C_W + $clog2(N);
  // Cycles counted from the accept edge (inclusive) to the first cycle with out_valid.
  localparam int unsigned DIV_LAT  = N + NUM_W + 1;
  localparam int unsigned ZERO_LAT = N + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             inValid;
  logic             inReady;
  logic [N*MU_W-1:0] mu;
  logic [N*C_W-1:0]  centre;
  logic             outValid;
  logic             outReady;
  logic [C_W-1:0]   crisp;
  logic             divZero;

  int unsigned testCount = 0;
  int unsigned failCount = 0;

  always #5 clk = ~clk;

  defuzz_centroid #(.N_SETS(N), .MU_W(MU_W), .C_W(C_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (inValid),
    .in_ready (inReady),
    .mu       (mu),
    .centre   (centre),
    .out_valid(outValid),
    .out_ready(outReady),
    .crisp    (crisp),
    .div_zero (divZero)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] pack5(input int unsigned a0, input int unsigned a1,
                                        input int unsigned a2, input int unsigned a3,
                                        input int unsigned a4);
    return {8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  // Centroid from the defining formula: weighted mean, rounded or truncated.
  task automatic refModel(input logic [39:0] muV, input logic [39:0] cV,
                          output int unsigned expCrisp, output int unsigned expDz);
    longint unsigned sumW = 0;
    longint unsigned sumMu = 0;
    longint unsigned m, c;
    for (int i = 0; i < int'(N); i++) begin
      m = longint'(muV[i*MU_W +: MU_W]);
      c = longint'(cV[i*C_W +: C_W]);
      sumW  += m * c;
      sumMu += m;
    end
    if (sumMu == 0) begin
      expCrisp = 0;
      expDz    = 1;
    end else begin
`ifdef DEFUZZ_ROUND_EN
      expCrisp = int'((2 * sumW + sumMu) / (2 * sumMu));
`else
      expCrisp = int'(sumW / sumMu);
`endif
      expDz = 0;
    end
  endtask

  task automatic runTxn(input string tag, input logic [39:0] muV, input logic [39:0] cV,
                        input int unsigned expCrisp, input int unsigned expDz,
                        input int unsigned holdCycles);
    int unsigned lat;
    int unsigned waitCnt;
    int unsigned expLat;
    logic [C_W-1:0] crispHold;
    logic dzHold;
    expLat  = (expDz != 0) ? ZERO_LAT : DIV_LAT;
    waitCnt = 0;
    while (!inReady && waitCnt < 50) begin
      @(posedge clk); #1; waitCnt++;
    end
    checkVal({tag, "_inready"}, 32'(inReady), 32'd1);
    inValid  = 1'b1;
    mu       = muV;
    centre   = cV;
    outReady = 1'b0;
    @(posedge clk); #1;
    inValid = 1'b0;
    lat = 1;
    while (!outValid && lat < 200) begin
      if (lat == 3) begin
        mu     = 40'({$urandom(), $urandom()});
        centre = 40'({$urandom(), $urandom()});
      end
      @(posedge clk); #1; lat++;
    end
    checkVal({tag, "_latency"}, lat, expLat);
    checkVal({tag, "_crisp"}, 32'(crisp), expCrisp);
    checkVal({tag, "_divzero"}, 32'(divZero), expDz);
    checkVal({tag, "_busy_ready"}, 32'(inReady), 32'd0);
    crispHold = crisp;
    dzHold    = divZero;
    for (int k = 0; k < int'(holdCycles); k++) begin
      inValid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      checkVal({tag, "_hold_valid"}, 32'(outValid), 32'd1);
      checkVal({tag, "_hold_crisp"}, 32'(crisp), 32'(crispHold));
      checkVal({tag, "_hold_dz"}, 32'(divZero), 32'(dzHold));
      checkVal({tag, "_hold_ready"}, 32'(inReady), 32'd0);
    end
    // in_valid may be high at the release edge; it must not be taken there.
    inValid  = 1'($urandom_range(0, 1));
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    inValid  = 1'b0;
    checkVal({tag, "_release_valid"}, 32'(outValid), 32'd0);
    checkVal({tag, "_release_ready"}, 32'(inReady), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [39:0] defC;
    logic [39:0] muV;
    logic [39:0] cV;
    int unsigned expCrisp;
    int unsigned expDz;
    int unsigned expRound;
    int unsigned spurious;

    defC = pack5(CENTRE_NL, CENTRE_NS, CENTRE_Z, CENTRE_PS, CENTRE_PL);
    rst = 1'b1; inValid = 1'b0; outReady = 1'b0; mu = '0; centre = '0;
    repeat (3) @(posedge clk);
    #1;
    checkVal("reset_ready", 32'(inReady), 32'd0);
    checkVal("reset_valid", 32'(outValid), 32'd0);
    checkVal("reset_crisp", 32'(crisp), 32'd0);
    checkVal("reset_dz", 32'(divZero), 32'd0);
    rst = 1'b0;
    #1;
    checkVal("release_ready", 32'(inReady), 32'd1);

    runTxn("zonly", pack5(0, 0, 200, 0, 0), defC, 128, 0, 10);

`ifdef DEFUZZ_ROUND_EN
    expRound = 224;
`else
    expRound = 223;
`endif
    runTxn("round", pack5(0, 0, 0, 100, 100), defC, expRound, 0, 1);

    runTxn("zero", pack5(0, 0, 0, 0, 0), defC, 0, 1, 2);

    runTxn("ctr50", pack5($urandom_range(1, 255), $urandom_range(1, 255),
                          $urandom_range(1, 255), $urandom_range(1, 255),
                          $urandom_range(1, 255)),
           pack5(50, 50, 50, 50, 50), 50, 0, 0);

    // Abort a transaction mid-divide.
    inValid = 1'b1;
    mu      = pack5(10, 20, 30, 40, 50);
    centre  = defC;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkVal("abort_rst_ready", 32'(inReady), 32'd0);
    checkVal("abort_rst_valid", 32'(outValid), 32'd0);
    rst = 1'b0;
    #1;
    checkVal("abort_release_ready", 32'(inReady), 32'd1);
    spurious = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (outValid) spurious++;
    end
    checkVal("abort_no_valid", spurious, 32'd0);
    runTxn("after_abort", pack5(255, 0, 0, 0, 0), defC, 0, 0, 0);

    for (int t = 0; t < 20; t++) begin
      if ($urandom_range(0, 7) == 0) muV = '0;
      else muV = pack5($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                       $urandom_range(0, 255), $urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) cV = defC;
      else cV = 40'({$urandom(), $urandom()});
      refModel(muV, cV, expCrisp, expDz);
      runTxn($sformatf("rand%0d", t), muV, cV, expCrisp, expDz, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
